// File: rtl/ibex_mem_responder_pkg.sv
// Shared types, parameter limits and the bus integrity encoder for the Ibex memory responder.
package ibex_mem_responder_pkg;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  localparam int unsigned DepthMin          = 4;
  localparam int unsigned RespLatencyMin    = 1;
  localparam int unsigned RespLatencyMax    = 4;
  localparam int unsigned MaxOutstandingMin = 1;
  localparam int unsigned MaxOutstandingMax = 4;

  // Same check-bit equations as prim_secded_inv_39_32_enc; the inverted code flips bits 1, 3 and 5.
  function automatic logic [6:0] intg_enc(logic [31:0] data);
    logic [6:0] parity;
    parity[0] = ^(data & 32'h2606_BD25);
    parity[1] = ^(data & 32'hDEBA_8050);
    parity[2] = ^(data & 32'h413D_89AA);
    parity[3] = ^(data & 32'h3123_4ED1);
    parity[4] = ^(data & 32'hC2C1_323B);
    parity[5] = ^(data & 32'h2DCC_624C);
    parity[6] = ^(data & 32'h9850_5586);
    return parity ^ 7'h2A;
  endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-latency response delay line: valid bit plus response word per stage, cleared by flush.
module ibex_mem_resp_pipe
  import ibex_mem_responder_pkg::*;
#(
  parameter int unsigned RespLatency = 1
) (
  input  logic     clk_i,
  input  logic     flush_i,
  input  logic     valid_i,
  input  mem_rsp_t rsp_i,
  output logic     valid_o,
  output mem_rsp_t rsp_o
);

  logic [RespLatency-1:0] valid_q, valid_d;
  mem_rsp_t               rsp_q [RespLatency];
  mem_rsp_t               rsp_d [RespLatency];

  always_comb begin
    valid_d    = valid_q;
    rsp_d      = rsp_q;
    valid_d[0] = valid_i;
    rsp_d[0]   = rsp_i;
    for (int i = 1; i < RespLatency; i++) begin
      valid_d[i] = valid_q[i-1];
      rsp_d[i]   = rsp_q[i-1];
    end
    // Flushing the data too keeps rdata_o/err_o at zero straight out of reset.
    if (flush_i) begin
      valid_d = '0;
      for (int i = 0; i < RespLatency; i++) begin
        rsp_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    valid_q <= valid_d;
    rsp_q   <= rsp_d;
  end

  assign valid_o = valid_q[RespLatency-1];
  assign rsp_o   = rsp_q[RespLatency-1];

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for one Ibex bus port: word RAM, address/integrity checks,
// outstanding-request limit and a fixed-latency response pipeline.
module ibex_mem_responder
  import ibex_mem_responder_pkg::*;
#(
  parameter int unsigned Depth          = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  input  logic        stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o
);

  localparam int unsigned   AddrW     = $clog2(Depth);
  localparam int unsigned   CntW      = $clog2(MaxOutstanding + 1);
  localparam logic [31:0]   SpanBytes = 32'(4 * Depth);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);

  if (Depth < DepthMin || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $fatal(1, "ibex_mem_responder: Depth must be a power of two >= 4");
  end
  if ((BaseAddr % (4 * Depth)) != 0) begin : g_bad_base
    $fatal(1, "ibex_mem_responder: BaseAddr must be aligned to 4*Depth");
  end
  if (RespLatency < RespLatencyMin || RespLatency > RespLatencyMax) begin : g_bad_latency
    $fatal(1, "ibex_mem_responder: RespLatency out of range 1..4");
  end
  if (MaxOutstanding < MaxOutstandingMin || MaxOutstanding > MaxOutstandingMax) begin : g_bad_outst
    $fatal(1, "ibex_mem_responder: MaxOutstanding out of range 1..4");
  end

  logic [31:0]      mem_q [Depth];
  logic [31:0]      offset;
  logic [AddrW-1:0] idx;
  logic             in_range;
  logic             misaligned;
  logic             be_none;
  logic             intg_bad;
  logic             err;
  logic             accept;
  logic             mem_we;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  mem_rsp_t         rsp_in;
  mem_rsp_t         rsp_out;

  // Registered count only: a response leaving this cycle cannot free a slot until the next.
  assign gnt_o  = req_i & ~stall_i & ~rst_i & (outstanding_q < CntMax);
  assign accept = req_i & gnt_o;

  always_comb begin
    offset     = addr_i - BaseAddr;
    idx        = offset[AddrW+1:2];
    in_range   = offset < SpanBytes;
    misaligned = addr_i[1:0] != 2'b00;
    be_none    = we_i & (be_i == 4'b0000);
    intg_bad   = we_i & (wdata_intg_i != intg_enc(wdata_i));
    err        = ~in_range | misaligned | be_none | intg_bad;
    mem_we     = accept & we_i & ~err;
    rsp_in     = '0;
    if (accept) begin
      rsp_in.err = err;
      if (!we_i && !err) begin
        rsp_in.rdata = mem_q[idx];
      end
    end
  end

  // RAM is deliberately not reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !rvalid_o) begin
      outstanding_d = outstanding_q + CntW'(1);
    end else if (!accept && rvalid_o) begin
      outstanding_d = outstanding_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  ibex_mem_resp_pipe #(
    .RespLatency(RespLatency)
  ) u_pipe (
    .clk_i   (clk_i),
    .flush_i (rst_i),
    .valid_i (accept),
    .rsp_i   (rsp_in),
    .valid_o (rvalid_o),
    .rsp_o   (rsp_out)
  );

  assign rdata_o      = rsp_out.rdata;
  assign err_o        = rsp_out.err;
  assign rdata_intg_o = intg_enc(rdata_o);

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed bench for ibex_mem_responder: a per-cycle reference model plus hand-computed pins.
module tb_ibex_mem_responder;

  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Base  = 32'h0010_0000;
  localparam int          RL    = 3;
  localparam int          MO    = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, req_i, gnt_o, we_i, stall_i, rvalid_o, err_o;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic [6:0]  wdata_intg_i, rdata_intg_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit live   = 1'b0;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_mem [int];
  int          gnt_log[$];
  int          rv_log[$];
  logic [31:0] rv_data_log[$];
  logic        rv_err_log[$];

  ibex_mem_responder #(
    .Depth(Depth), .BaseAddr(Base), .RespLatency(RL), .MaxOutstanding(MO)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .wdata_intg_i(wdata_intg_i),
    .stall_i(stall_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .rdata_intg_o(rdata_intg_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inverted SECDED(39,32) check bits, bit by bit from the code's column masks.
  function automatic logic [6:0] ref_enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  r;
    m[0] = 32'h2606BD25; m[1] = 32'hDEBA8050; m[2] = 32'h413D89AA; m[3] = 32'h31234ED1;
    m[4] = 32'hC2C1323B; m[5] = 32'h2DCC624C; m[6] = 32'h98505586;
    r = 7'b0101010;
    for (int i = 0; i < 7; i++)
      for (int b = 0; b < 32; b++)
        if (m[i][b]) r[i] = r[i] ^ d[b];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin : cmp
    bit          exp_gnt;
    bit          er;
    bit          in_rng;
    int          widx;
    exp_t        e;
    logic [31:0] word;
    if (live) begin
      exp_gnt = req_i && !stall_i && !rst_i && (exp_q.size() < MO);
      check("gnt", gnt_o, exp_gnt);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("rvalid", rvalid_o, 1);
        check("err", err_o, e.err);
        check("rdata", rdata_o, e.rdata);
        check("rdata_intg", rdata_intg_o, ref_enc(e.rdata));
      end else begin
        check("rvalid_idle", rvalid_o, 0);
      end
      if (rvalid_o) begin
        rv_log.push_back(cyc);
        rv_data_log.push_back(rdata_o);
        rv_err_log.push_back(err_o);
      end
      if (req_i && gnt_o) gnt_log.push_back(cyc);
      if (rst_i) begin
        exp_q.delete();
      end else if (exp_gnt) begin
        in_rng = (addr_i >= Base) && (addr_i < Base + 32'(4 * Depth));
        er = !in_rng || (addr_i[1:0] != 2'b00) || (we_i && be_i == 4'h0) ||
             (we_i && wdata_intg_i != ref_enc(wdata_i));
        widx    = int'((addr_i - Base) / 4);
        e.due   = cyc + RL;
        e.err   = er;
        e.rdata = 32'h0;
        if (!er && we_i) begin
          word = mdl_mem.exists(widx) ? mdl_mem[widx] : 32'h0;
          for (int k = 0; k < 4; k++)
            if (be_i[k]) word[8*k +: 8] = wdata_i[8*k +: 8];
          mdl_mem[widx] = word;
        end else if (!er) begin
          e.rdata = mdl_mem.exists(widx) ? mdl_mem[widx] : 32'hxxxx_xxxx;
        end
        exp_q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit bad_intg);
    int waited = 0;
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    wdata_intg_i = ref_enc(wdata) ^ {6'b0, bad_intg};
    forever begin
      @(negedge clk_i);
      if (gnt_o) break;
      waited++;
      if (waited > 40) begin
        checks++; errors++;
        $display("FAIL issue_timeout: no grant for addr %h after %0d cycles, required a grant", addr, waited);
        break;
      end
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); rv_log.delete(); rv_data_log.delete(); rv_err_log.delete();
  endtask

  function automatic logic [31:0] rvd(input int i);
    if (i < rv_data_log.size()) return rv_data_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic rve(input int i);
    if (i < rv_err_log.size()) return rv_err_log[i];
    return 1'bx;
  endfunction

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnt_rel [6];
    int rv_rel  [6];
    int base_c;
    int stall_low;
    gnt_rel = '{0, 1, 4, 5, 8, 9};
    rv_rel  = '{3, 4, 7, 8, 11, 12};

    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = Base;
    wdata_i = '0; wdata_intg_i = '0; stall_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; live = 1'b1;
    @(negedge clk_i);
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_rdata_intg", rdata_intg_o, 7'h2A);
    check("rst_outstanding", u_dut.outstanding_q, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_i = 1'b0;

    // Write then read back
    clear_logs();
    issue(1'b1, 4'hF, Base + 32'h4, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 4'hF, Base + 32'h4, 32'h0, 1'b0);
    idle(RL + 4);
    check("wr_rsp_err", rve(0), 0);
    check("wr_rsp_rdata", rvd(0), 32'h0);
    check("rd_rsp_rdata", rvd(1), 32'hDEADBEEF);
    check("rd_rsp_count", rv_log.size(), 2);

    // Partial write
    clear_logs();
    issue(1'b1, 4'hF, Base + 32'h8, 32'h11223344, 1'b0);
    issue(1'b1, 4'b0101, Base + 32'h8, 32'hAABBCCDD, 1'b0);
    issue(1'b0, 4'h1, Base + 32'h8, 32'h0, 1'b0);
    idle(RL + 4);
    check("partial_rdata", rvd(2), 32'h11BB33DD);

    // Error responses, then confirm the word is unchanged
    clear_logs();
    issue(1'b0, 4'hF, Base + 32'h1000, 32'h0, 1'b0);
    issue(1'b0, 4'hF, Base + 32'h2, 32'h0, 1'b0);
    issue(1'b1, 4'hF, Base + 32'h8, 32'h55555555, 1'b1);
    issue(1'b1, 4'h0, Base + 32'h8, 32'hFFFFFFFF, 1'b0);
    issue(1'b0, 4'hF, Base - 32'h4, 32'h0, 1'b0);
    issue(1'b0, 4'hF, Base + 32'h8, 32'h0, 1'b0);
    idle(RL + 4);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("err_rsp%0d_err", i), rve(i), 1);
      check($sformatf("err_rsp%0d_rdata", i), rvd(i), 32'h0);
    end
    check("err_word_intact", rvd(5), 32'h11BB33DD);

    // Throughput with the outstanding limit below the latency
    for (int i = 0; i < 6; i++)
      issue(1'b1, 4'hF, Base + 32'(4 * (16 + i)), 32'hC0DE0000 + 32'(i), 1'b0);
    idle(RL + 4);
    clear_logs();
    for (int i = 0; i < 6; i++)
      issue(1'b0, 4'hF, Base + 32'(4 * (16 + i)), 32'h0, 1'b0);
    idle(16);
    base_c = at(gnt_log, 0);
    check("tp_gnt_count", gnt_log.size(), 6);
    check("tp_rv_count", rv_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("tp_gnt_cycle%0d", i), at(gnt_log, i) - base_c, gnt_rel[i]);
      check($sformatf("tp_rv_cycle%0d", i), at(rv_log, i) - base_c, rv_rel[i]);
      check($sformatf("tp_rdata%0d", i), rvd(i), 32'hC0DE0000 + 32'(i));
    end

    // Stall hook
    clear_logs();
    stall_i = 1'b1;
    stall_low = -1;
    fork
      begin
        repeat (5) @(posedge clk_i);
        #1;
        stall_low = cyc;
        stall_i = 1'b0;
      end
      issue(1'b0, 4'hF, Base + 32'h40, 32'h0, 1'b0);
    join
    idle(RL + 3);
    check("stall_gnt_count", gnt_log.size(), 1);
    check("stall_gnt_cycle", at(gnt_log, 0), stall_low);
    check("stall_rdata", rvd(0), 32'hC0DE0000);

    // Reset mid-flight, with a write attempted during the reset cycle
    clear_logs();
    issue(1'b0, 4'hF, Base + 32'h4, 32'h0, 1'b0);
    issue(1'b0, 4'hF, Base + 32'h8, 32'h0, 1'b0);
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = Base + 32'h4;
    wdata_i = 32'hBAD0BAD0; wdata_intg_i = ref_enc(32'hBAD0BAD0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_i = 1'b0;
    idle(8);
    check("rst_mid_gnt_count", gnt_log.size(), 2);
    check("rst_mid_rv_count", rv_log.size(), 0);
    check("rst_mid_outstanding", u_dut.outstanding_q, 0);
    clear_logs();
    issue(1'b0, 4'hF, Base + 32'h4, 32'h0, 1'b0);
    issue(1'b0, 4'hF, Base + 32'h8, 32'h0, 1'b0);
    idle(RL + 4);
    check("rst_mem_word1", rvd(0), 32'hDEADBEEF);
    check("rst_mem_word2", rvd(1), 32'h11BB33DD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
